// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Fetch -> decode handshake bundle.
//   if_valid  : fetch holds a valid instruction in if_inst/if_pc
//   if_inst   : registered instruction word
//   if_pc     : byte address of if_inst
//   id_ready  : decode accepts the instruction this cycle
// master = fetch stage, slave = decode stage.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (output if_valid, output if_inst, output if_pc, input id_ready);
    modport slave  (input  if_valid, input  if_inst, input  if_pc, output id_ready);
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC, drives a combinational instruction
// memory and registers the returned word into the fetch/decode register,
// which is handed to decode over a valid/ready handshake.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   pc              : fetch address to instruction memory (the PC register)
//   inst_code       : memory data for pc, same cycle
//   redirect_valid  : restart fetch at redirect_pc (flushes held instruction)
//   redirect_pc     : redirect target byte address
//   dec             : decode handshake (if_valid/if_inst/if_pc/id_ready)
//   fetch_done      : high while in DONE
//   fetch_err       : one-cycle pulse on misaligned/out-of-range redirect
//   perf_fetched,
//   perf_stalls     : saturating counters, only with FETCH_PERF_EN defined
//
// Optional feature: define FETCH_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] inst_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master dec,
    output logic        fetch_done,
    output logic        fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    // WAIT gives memory one cycle to settle after reset before the first capture
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic        r_err, w_err_nxt;
    logic        w_capture;
    logic        w_slot_free;
    logic        w_misalign;
    logic        w_oor;

    assign w_slot_free = !r_valid || dec.id_ready;
    assign w_misalign  = (redirect_pc[1:0] != 2'b00);
    assign w_oor       = (redirect_pc >= MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_inst  <= 32'h0;
            r_if_pc <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_inst  <= w_inst_nxt;
            r_if_pc <= w_if_pc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_inst_nxt  = r_inst;
        w_if_pc_nxt = r_if_pc;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;

        if (redirect_valid) begin
            // Flush wins over a same-cycle decode accept; no capture this cycle
            w_valid_nxt = 1'b0;
            w_err_nxt   = w_misalign || w_oor;
            if (w_oor) begin
                w_pc_nxt    = RESET_PC;
                w_state_nxt = S_DONE;
            end else begin
                w_pc_nxt    = {redirect_pc[31:2], 2'b00};
                w_state_nxt = S_RUN;
            end
        end else begin
            unique case (r_state)
                S_WAIT: w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_slot_free) begin
                        w_capture   = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_inst_nxt  = inst_code;
                        w_if_pc_nxt = r_pc;
                        if (r_pc == LAST_PC) w_state_nxt = S_DONE;
                        else                 w_pc_nxt    = r_pc + 32'd4;
                    end
                end
                S_DONE: begin
                    // Drain the last instruction, then stay empty
                    if (r_valid && dec.id_ready) w_valid_nxt = 1'b0;
                end
                default: w_state_nxt = S_WAIT;
            endcase
        end
    end

    assign pc          = r_pc;
    assign dec.if_valid = r_valid;
    assign dec.if_inst  = r_inst;
    assign dec.if_pc    = r_if_pc;
    assign fetch_done  = (r_state == S_DONE);
    assign fetch_err   = r_err;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;
    logic        w_stall_cyc;

    assign w_stall_cyc = (r_state == S_RUN) && r_valid && !dec.id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'h0;
            r_perf_stalls  <= 32'h0;
        end else begin
            if (w_capture && (r_perf_fetched != 32'hFFFF_FFFF))
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_stall_cyc && (r_perf_stalls != 32'hFFFF_FFFF))
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;
`else
    logic w_unused;
    assign w_unused = w_capture;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and drives the combinational instruction memory's pc input.
- Captures the returned 32-bit inst_code into a fetch/decode pipeline register.
- Presents the instruction to the decode stage over a valid/ready handshake, with stall, redirect/flush and end-of-program handling.

Parameters:
- MEM_BYTES, 32: size of instruction memory in bytes; multiple of 4.
- RESET_PC, 0: PC value loaded on reset; word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; also drives the instruction memory's reset.
- pc  output  32  fetch address to instruction memory; equals internal PC register.
- inst_code  input  32  instruction returned by memory for the current pc, same cycle.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target byte address.
- id_ready  input  1  decode accepts if_inst this cycle when if_valid=1.
- if_valid  output  1  if_inst/if_pc hold a valid instruction.
- if_inst  output  32  registered instruction word.
- if_pc  output  32  address of if_inst.
- fetch_done  output  1  high in DONE state.
- fetch_err  output  1  one-cycle pulse on a misaligned or out-of-range redirect.

Behaviour:
- Reset (reset=1 at edge):
  - pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, fetch_done=0, fetch_err=0.
  - State goes to WAIT.
- States: WAIT, RUN, DONE.
- WAIT: one cycle after reset deasserts, giving memory contents time to settle. No capture. Unconditionally goes to RUN.
- RUN:
  - Load condition is slot_free = !if_valid || id_ready.
  - When slot_free, capture on the edge:
    - if_inst<=inst_code, if_pc<=pc, if_valid<=1.
    - If pc==MEM_BYTES-4: go to DONE, pc holds.
    - Otherwise pc<=pc+4.
  - When !slot_free (stall): pc, if_inst, if_pc and if_valid all hold.
- Handshake:
  - A transfer occurs on any edge with if_valid && id_ready.
  - Throughput is one instruction per cycle while id_ready=1.
  - Latency is 1 cycle from pc presentation to if_valid.
  - if_inst/if_pc are stable while if_valid && !id_ready.
- DONE:
  - No new captures. if_valid clears after the pending instruction transfers.
  - fetch_done=1. pc holds.
- Redirect (any state except during reset; priority reset > redirect > normal):
  - if_valid<=0, which flushes the held instruction, even if id_ready=1 in the same cycle.
  - pc<=redirect_pc with bits [1:0] cleared.
  - If redirect_pc[1:0]!=0: fetch_err pulses 1 for one cycle, and fetch continues at the aligned address.
  - If redirect_pc>=MEM_BYTES: fetch_err pulses, pc<=RESET_PC, and state goes to DONE.
  - Otherwise state goes to RUN, leaving DONE if necessary. No capture occurs in the redirect cycle.
- Arithmetic: pc+4 is 32-bit unsigned. Wrap-around is never reached, because DONE stops fetch at MEM_BYTES-4.
- Reset mid-operation: takes effect at the next edge regardless of state, stall or redirect; the pending instruction is discarded.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_stalls[31:0], both cleared by reset.
  - perf_fetched increments on each capture.
  - perf_stalls increments on each RUN cycle with if_valid && !id_ready.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset 2 cycles, then id_ready=1 -> after WAIT, if_valid=1 with if_inst=0x00940333/if_pc=0, then 0x413903b3/4, then 0x035a02b3/8 on consecutive cycles.
- id_ready=0 for 3 cycles while if_inst=0x413903b3 -> if_inst, if_pc=4 and pc=8 held; after id_ready=1, the next is 0x035a02b3/8.
- Run to end -> last transfer 0x00f768b3/if_pc=28; fetch_done=1; if_valid=0 after the transfer; no further captures.
- redirect_valid with redirect_pc=0x10 while holding inst at pc 8 -> held inst flushed; next if_inst=0x019c1eb3/if_pc=0x10; fetch_err=0.
- redirect_pc=0x13 -> fetch_err one-cycle pulse, next if_pc=0x10; redirect_pc=0x40 -> fetch_err pulse, fetch_done=1, if_valid=0.
- reset asserted mid-stall at pc 12 -> next cycle pc=0, if_valid=0, state WAIT; refetch starts with 0x00940333.
